// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide unit with its sequencing FSM and the HI/LO registers.
// Optional feature: define MDU_FLUSH_EN to add the 'flush' abort input.
module mdu_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
`ifdef MDU_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        start,
    input  logic [3:0]  MDUCtrl,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUResult
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
    localparam logic [3:0] OpMfhi  = 4'd7;

    typedef enum logic {StIdle, StRun} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              busy_q;
    logic [31:0]       hi_q, lo_q;
    logic [3:0]        op_q;
    logic [31:0]       a_q, b_q;

    logic              abort;
`ifdef MDU_FLUSH_EN
    assign abort = flush;
`else
    assign abort = 1'b0;
`endif

    logic is_md, is_div;
    assign is_md  = (MDUCtrl >= OpMult) && (MDUCtrl <= OpDivu);
    assign is_div = (MDUCtrl == OpDiv) || (MDUCtrl == OpDivu);

    // Arithmetic on the latched operands only, so srcA/srcB may change freely during RUN.
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quot_s, rem_s;
    logic        [31:0] quot_u, rem_u;
    logic               div_ovf;

    assign prod_s  = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u  = {32'd0, a_q} * {32'd0, b_q};
    assign quot_s  = $signed(a_q) / $signed(b_q);
    assign rem_s   = $signed(a_q) % $signed(b_q);
    assign quot_u  = a_q / b_q;
    assign rem_u   = a_q % b_q;
    // Most-negative / -1 overflows the quotient; pin it to a defined result.
    assign div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

    logic        res_we;
    logic [31:0] res_hi, res_lo;

    // Select the HI/LO result for the latched op; divide by zero suppresses the write.
    always_comb begin
        res_we = 1'b1;
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op_q)
            OpMult:  {res_hi, res_lo} = prod_s;
            OpMultu: {res_hi, res_lo} = prod_u;
            OpDiv: begin
                if (b_q == 32'd0) begin
                    res_we = 1'b0;
                end else if (div_ovf) begin
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_hi = rem_s;
                    res_lo = quot_s;
                end
            end
            OpDivu: begin
                if (b_q == 32'd0) begin
                    res_we = 1'b0;
                end else begin
                    res_hi = rem_u;
                    res_lo = quot_u;
                end
            end
            default: res_we = 1'b0;
        endcase
    end

    // Sequencer: launch, count down, commit HI/LO on the last busy cycle; MTHI/MTLO when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (abort) begin
                        // flush suppresses any launch or move-to in this cycle
                    end else if (start && is_md) begin
                        op_q    <= MDUCtrl;
                        a_q     <= srcA;
                        b_q     <= srcB;
                        cnt_q   <= is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end else if (!start && MDUCtrl == OpMthi) begin
                        hi_q <= srcA;
                    end else if (!start && MDUCtrl == OpMtlo) begin
                        lo_q <= srcA;
                    end
                end
                StRun: begin
                    if (abort) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (cnt_q == CntW'(1)) begin
                        if (res_we) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = busy_q;
    assign HI        = hi_q;
    assign LO        = lo_q;
    assign MDUResult = (MDUCtrl == OpMfhi) ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: stimulus pushes expectations, a monitor compares.
module tb_mdu_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [3:0]  ctrl;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo, res;
`ifdef MDU_FLUSH_EN
    logic        flush;
`endif

    mdu_sequencer #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
`ifdef MDU_FLUSH_EN
        .flush    (flush),
`endif
        .start    (start),
        .MDUCtrl  (ctrl),
        .srcA     (a),
        .srcB     (b),
        .busy     (busy),
        .HI       (hi),
        .LO       (lo),
        .MDUResult(res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Completion expectations: checked when busy falls.
    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    // Snapshot expectations: checked at the next falling clock edge.
    // sel: 0 busy, 1 HI, 2 LO, 3 MDUResult, other = expired wait bound.
    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } snap_t;

    exp_t  sb[$];
    snap_t snaps[$];
    exp_t  mon_e;
    snap_t mon_s;
    int    n_vec = 0;
    int    n_miss = 0;
    int    busy_len = 0;
    logic  prev_busy = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        while (snaps.size() != 0) begin
            mon_s = snaps.pop_front();
            case (mon_s.sel)
                0: chk(mon_s.name, {31'd0, busy}, mon_s.val);
                1: chk(mon_s.name, hi, mon_s.val);
                2: chk(mon_s.name, lo, mon_s.val);
                3: chk(mon_s.name, res, mon_s.val);
                default: begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL %s: wait bound expired, completion never seen", mon_s.name);
                end
            endcase
        end
        if (busy === 1'b1) begin
            busy_len++;
        end else if (prev_busy === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_done: got a completion, expected none");
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_hi"}, hi, mon_e.hi);
                chk({mon_e.name, "_lo"}, lo, mon_e.lo);
                chk({mon_e.name, "_busylen"}, 32'(busy_len), 32'(mon_e.len));
            end
            busy_len = 0;
        end
        prev_busy = busy;
    end

    // Drive one cycle of inputs; entered and left at posedge+1.
    task automatic drive(input logic [3:0] c, input logic st, input logic [31:0] x,
                         input logic [31:0] y);
        ctrl  = c;
        start = st;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        ctrl  = 4'd0;
    endtask

    task automatic launch(input string nm, input logic [3:0] c, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                          input int len);
        exp_t e;
        e.name = nm;
        e.hi   = eh;
        e.lo   = el;
        e.len  = len;
        sb.push_back(e);
        drive(c, 1'b1, x, y);
    endtask

    task automatic expect_sig(input string nm, input int sel, input logic [31:0] v);
        snap_t s;
        s.name = nm;
        s.sel  = sel;
        s.val  = v;
        snaps.push_back(s);
    endtask

    // Let the monitor evaluate pending snapshots with inputs held.
    task automatic sync();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input string nm);
        int i;
        i = 0;
        while (sb.size() != 0 && i < 200) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (sb.size() != 0) begin
            expect_sig(nm, 99, 32'd0);
            sb.delete();
            sync();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        ctrl    = 4'd0;
        a       = 32'd0;
        b       = 32'd0;
`ifdef MDU_FLUSH_EN
        flush   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        expect_sig("rst_busy", 0, 32'd0);
        expect_sig("rst_hi", 1, 32'd0);
        expect_sig("rst_lo", 2, 32'd0);
        expect_sig("rst_res", 3, 32'd0);
        sync();
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        launch("mult_neg", 4'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        settle("mult_neg");
        launch("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5);
        settle("multu");
        launch("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        settle("div_neg");
        launch("mult_m1m1", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 5);
        settle("mult_m1m1");
        launch("multu_max", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 5);
        settle("multu_max");
        launch("div_negdvs", 4'd3, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 10);
        settle("div_negdvs");
        launch("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10);
        settle("div_ovf");
        launch("divu_max", 4'd4, 32'hFFFF_FFFF, 32'd10, 32'h5, 32'h1999_9999, 10);
        settle("divu_max");

        // start with a non-launch op is ignored
        drive(4'd7, 1'b1, 32'd1, 32'd1);
        expect_sig("nonmd_start_busy", 0, 32'd0);
        sync();

        drive(4'd5, 1'b0, 32'h1234_5678, 32'd0);
        drive(4'd6, 1'b0, 32'd0, 32'd0);
        expect_sig("mthi_hi", 1, 32'h1234_5678);
        expect_sig("mtlo_lo", 2, 32'd0);
        sync();

        launch("divu_by0", 4'd4, 32'd7, 32'd0, 32'h1234_5678, 32'd0, 10);
        settle("divu_by0");

        ctrl = 4'd7;
        expect_sig("mfhi_res", 3, 32'h1234_5678);
        sync();
        ctrl = 4'd8;
        expect_sig("mflo_res", 3, 32'd0);
        sync();
        ctrl = 4'd0;

        // operand changes, restart and MTLO/MTHI during RUN must not disturb the result
        launch("div_disturb", 4'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        drive(4'd3, 1'b1, 32'd5, 32'd1);
        drive(4'd6, 1'b0, 32'hDEAD_BEEF, 32'd3);
        drive(4'd5, 1'b0, 32'hCAFE_F00D, 32'd3);
        settle("div_disturb");

        // reset in the 3rd busy cycle
        begin
            exp_t e;
            e.name = "mult_rst";
            e.hi   = 32'd0;
            e.lo   = 32'd0;
            e.len  = 2;
            sb.push_back(e);
        end
        drive(4'd1, 1'b1, 32'd9, 32'd9);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        expect_sig("midrst_busy", 0, 32'd0);
        expect_sig("midrst_hi", 1, 32'd0);
        expect_sig("midrst_lo", 2, 32'd0);
        sync();
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        launch("mult_after_rst", 4'd1, 32'd4, 32'd5, 32'd0, 32'd20, 5);
        settle("mult_after_rst");

`ifdef MDU_FLUSH_EN
        drive(4'd5, 1'b0, 32'hAAAA_0000, 32'd0);
        drive(4'd6, 1'b0, 32'hAAAA_0000, 32'd0);
        begin
            exp_t e;
            e.name = "div_flush";
            e.hi   = 32'hAAAA_0000;
            e.lo   = 32'hAAAA_0000;
            e.len  = 4;
            sb.push_back(e);
        end
        drive(4'd3, 1'b1, 32'd100, 32'd7);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        settle("div_flush");

        flush = 1'b1;
        drive(4'd3, 1'b1, 32'd100, 32'd7);
        flush = 1'b0;
        expect_sig("flush_start_busy", 0, 32'd0);
        sync();

        flush = 1'b1;
        drive(4'd5, 1'b0, 32'd1, 32'd0);
        flush = 1'b0;
        expect_sig("flush_mthi_hi", 1, 32'hAAAA_0000);
        sync();

        launch("div_after_flush", 4'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        settle("div_after_flush");
`endif

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
